// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit pipelined CPU datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   CPU_DW / CPU_RW       default datapath and register-specifier widths
//   CTRL_* indices        bit positions inside the 6-bit control vector
//                         {LdByte, MemOp, MemRead, MemWrite, RegWrite, Halt}
//   FWD_*                 EX operand-mux select encodings
//   BUBBLE_INSTR          instruction word injected for a bubble
package cpu_pkg;

    localparam int CPU_DW = 16;
    localparam int CPU_RW = 4;
    localparam int CTRL_W = 6;

    // Control vector bit positions (MSB first: LdByte .. Halt).
    localparam int CTRL_LDBYTE   = 5;
    localparam int CTRL_MEMOP    = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_HALT     = 0;

    // Operand select encodings. 2'b11 is never produced.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

    // A load that writes a register: the only producer whose result is
    // not yet available for forwarding when its consumer reaches EX.
    function automatic logic is_reg_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD] & ctrl[CTRL_REGWRITE];
    endfunction

endpackage : cpu_pkg

// File: rtl/id_ex_pipe_fwd_unit.sv
// Forwarding select for one EX source operand.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   valid_ex      in  1   EX holds a real instruction
//   src_ex        in  RW  source specifier held in EX
//   rd_mem        in  RW  destination of instruction in MEM
//   regwrite_mem  in  1   MEM instruction writes a register
//   rd_wb         in  RW  destination of instruction in WB
//   regwrite_wb   in  1   WB instruction writes a register
//   fwd_sel       out 2   FWD_MEM / FWD_WB / FWD_REG
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int RW = CPU_RW
) (
    input  logic          valid_ex,
    input  logic [RW-1:0] src_ex,
    input  logic [RW-1:0] rd_mem,
    input  logic          regwrite_mem,
    input  logic [RW-1:0] rd_wb,
    input  logic          regwrite_wb,
    output logic [1:0]    fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    // R0 reads as zero, so a write to R0 is never a forwarding source.
    assign mem_hit = regwrite_mem & (rd_mem != '0) & (rd_mem == src_ex);
    assign wb_hit  = regwrite_wb  & (rd_wb  != '0) & (rd_wb  == src_ex);

    // MEM holds the younger result, so it takes priority over WB.
    always_comb begin
        fwd_sel = FWD_REG;
        if (valid_ex) begin
            if (mem_hit) begin
                fwd_sel = FWD_MEM;
            end else if (wb_hit) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule : fwd_unit

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection and EX forwarding selects.
// Latency: ID -> EX exactly one cycle; stall_ID / ForwardA / ForwardB combinational.
// Backpressure: freeze holds all state; load-use hazard inserts one bubble and raises stall_ID.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   instr_ID, rd1_ID, rd2_ID, pcs_ID   DW  datapath values from ID
//   rs_ID, rt_ID, rd_ID                RW  register specifiers from ID
//   use_rs_ID, use_rt_ID               1   ID instruction reads rs / rt
//   ctrl_ID                            6   {LdByte, MemOp, MemRead, MemWrite, RegWrite, Halt}
//   flush                              1   kill instruction entering EX
//   freeze                             1   hold all state this cycle
//   rd_MEM, regwrite_MEM               MEM-stage destination and write enable
//   rd_WB, regwrite_WB                 WB-stage destination and write enable
//   instr_EX .. ctrl_EX, valid_EX      registered EX-stage copies
//   ForwardA, ForwardB                 2   rs / rt operand selects
//   stall_ID                           1   load-use hazard, hold PC and IF/ID
module id_ex_pipe
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int RW = CPU_RW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     instr_ID,
    input  logic [DW-1:0]     rd1_ID,
    input  logic [DW-1:0]     rd2_ID,
    input  logic [DW-1:0]     pcs_ID,
    input  logic [RW-1:0]     rs_ID,
    input  logic [RW-1:0]     rt_ID,
    input  logic [RW-1:0]     rd_ID,
    input  logic              use_rs_ID,
    input  logic              use_rt_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic              flush,
    input  logic              freeze,
    input  logic [RW-1:0]     rd_MEM,
    input  logic              regwrite_MEM,
    input  logic [RW-1:0]     rd_WB,
    input  logic              regwrite_WB,
    output logic [DW-1:0]     instr_EX,
    output logic [DW-1:0]     rd1_EX,
    output logic [DW-1:0]     rd2_EX,
    output logic [DW-1:0]     pcs_EX,
    output logic [RW-1:0]     rs_EX,
    output logic [RW-1:0]     rt_EX,
    output logic [RW-1:0]     rd_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic              valid_EX,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              stall_ID
);

    // Everything that travels from ID into EX, kept as one packed bundle so
    // bubble, hold and load all act on the whole stage uniformly.
    typedef struct packed {
        logic [DW-1:0]     instr;
        logic [DW-1:0]     rd1;
        logic [DW-1:0]     rd2;
        logic [DW-1:0]     pcs;
        logic [RW-1:0]     rs;
        logic [RW-1:0]     rt;
        logic [RW-1:0]     rd;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } ex_stage_t;

    ex_stage_t ex_q;
    ex_stage_t ex_d;
    ex_stage_t id_in;
    ex_stage_t bubble;

    logic hazard_hit;
    logic rs_dep;
    logic rt_dep;
    logic insert_bubble;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX has no result until after MEM, so a
    // dependent instruction in ID must wait one cycle. A flush kills the
    // ID instruction anyway, so there is nothing to stall for.
    // ------------------------------------------------------------------
    assign rs_dep = use_rs_ID & (rs_ID == ex_q.rd);
    assign rt_dep = use_rt_ID & (rt_ID == ex_q.rd);

    assign hazard_hit = ex_q.valid
                      & is_reg_load(ex_q.ctrl)
                      & (ex_q.rd != '0)
                      & (rs_dep | rt_dep);

    assign stall_ID      = hazard_hit & ~flush;
    assign insert_bubble = flush | stall_ID;

    // ------------------------------------------------------------------
    // Next-state selection: freeze > bubble > load.
    // ------------------------------------------------------------------
    always_comb begin
        id_in       = '0;
        id_in.instr = instr_ID;
        id_in.rd1   = rd1_ID;
        id_in.rd2   = rd2_ID;
        id_in.pcs   = pcs_ID;
        id_in.rs    = rs_ID;
        id_in.rt    = rt_ID;
        id_in.rd    = rd_ID;
        id_in.ctrl  = ctrl_ID;
        id_in.valid = 1'b1;
    end

    // A bubble clears all control, so RegWrite/MemWrite cannot leak through.
    always_comb begin
        bubble       = '0;
        bubble.instr = DW'(BUBBLE_INSTR);
    end

    always_comb begin
        ex_d = id_in;
        if (freeze) begin
            ex_d = ex_q;
        end else if (insert_bubble) begin
            ex_d = bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign instr_EX = ex_q.instr;
    assign rd1_EX   = ex_q.rd1;
    assign rd2_EX   = ex_q.rd2;
    assign pcs_EX   = ex_q.pcs;
    assign rs_EX    = ex_q.rs;
    assign rt_EX    = ex_q.rt;
    assign rd_EX    = ex_q.rd;
    assign ctrl_EX  = ex_q.ctrl;
    assign valid_EX = ex_q.valid;

    // ------------------------------------------------------------------
    // Forwarding selects for the two EX operands.
    // ------------------------------------------------------------------
    fwd_unit #(
        .RW(RW)
    ) u_fwd_rs (
        .valid_ex     (ex_q.valid),
        .src_ex       (ex_q.rs),
        .rd_mem       (rd_MEM),
        .regwrite_mem (regwrite_MEM),
        .rd_wb        (rd_WB),
        .regwrite_wb  (regwrite_WB),
        .fwd_sel      (ForwardA)
    );

    fwd_unit #(
        .RW(RW)
    ) u_fwd_rt (
        .valid_ex     (ex_q.valid),
        .src_ex       (ex_q.rt),
        .rd_mem       (rd_MEM),
        .regwrite_mem (regwrite_MEM),
        .rd_wb        (rd_WB),
        .regwrite_wb  (regwrite_WB),
        .fwd_sel      (ForwardB)
    );

endmodule : id_ex_pipe

// File: tb/tb_id_ex_pipe.sv
// Directed, table-driven bench for id_ex_pipe.
// Latency: checks registered outputs #1 after each posedge.
// Backpressure: exercises freeze holds, load-use stall and flush bubbles.
module tb_id_ex_pipe;

    localparam logic [5:0] C_ADD = 6'b000010;  // RegWrite
    localparam logic [5:0] C_LW  = 6'b011010;  // MemOp|MemRead|RegWrite
    localparam logic [5:0] C_SW  = 6'b010100;  // MemOp|MemWrite
    localparam logic [5:0] C_HLT = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_ID, rd1_ID, rd2_ID, pcs_ID;
    logic [3:0]  rs_ID, rt_ID, rd_ID;
    logic        use_rs_ID, use_rt_ID;
    logic [5:0]  ctrl_ID;
    logic        flush, freeze;
    logic [3:0]  rd_MEM, rd_WB;
    logic        regwrite_MEM, regwrite_WB;
    logic [15:0] instr_EX, rd1_EX, rd2_EX, pcs_EX;
    logic [3:0]  rs_EX, rt_EX, rd_EX;
    logic [5:0]  ctrl_EX;
    logic        valid_EX;
    logic [1:0]  ForwardA, ForwardB;
    logic        stall_ID;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .instr_ID(instr_ID), .rd1_ID(rd1_ID), .rd2_ID(rd2_ID), .pcs_ID(pcs_ID),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
        .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .ctrl_ID(ctrl_ID),
        .flush(flush), .freeze(freeze),
        .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM),
        .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
        .instr_EX(instr_EX), .rd1_EX(rd1_EX), .rd2_EX(rd2_EX), .pcs_EX(pcs_EX),
        .rs_EX(rs_EX), .rt_EX(rt_EX), .rd_EX(rd_EX), .ctrl_EX(ctrl_EX),
        .valid_EX(valid_EX), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall_ID(stall_ID)
    );

    typedef struct {
        logic        rst_n, flush, freeze;
        logic [15:0] instr;
        logic [3:0]  rs, rt, rd;
        logic        urs, urt;
        logic [5:0]  ctrl;
        logic [3:0]  rd_mem;
        logic        rw_mem;
        logic [3:0]  rd_wb;
        logic        rw_wb;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [3:0]  e_rs, e_rt, e_rd;
        logic [5:0]  e_ctrl;
        logic [1:0]  e_fa, e_fb;
        logic        e_stall;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic fl, input logic fz, input logic [15:0] ins,
        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
        input logic urs, input logic urt, input logic [5:0] ctl,
        input logic [3:0] rdm, input logic rwm, input logic [3:0] rdw, input logic rww,
        input logic ev, input logic [15:0] ei, input logic [3:0] ers,
        input logic [3:0] ert, input logic [3:0] erd, input logic [5:0] ectl,
        input logic [1:0] efa, input logic [1:0] efb, input logic est);
        vec_t v;
        v.rst_n = r; v.flush = fl; v.freeze = fz; v.instr = ins;
        v.rs = rs; v.rt = rt; v.rd = rd; v.urs = urs; v.urt = urt; v.ctrl = ctl;
        v.rd_mem = rdm; v.rw_mem = rwm; v.rd_wb = rdw; v.rw_wb = rww;
        v.e_valid = ev; v.e_instr = ei; v.e_rs = ers; v.e_rt = ert; v.e_rd = erd;
        v.e_ctrl = ectl; v.e_fa = efa; v.e_fb = efb; v.e_stall = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operand data is derived from the instruction word so held/loaded
    // values can be predicted from the expected instruction alone.
    task automatic drive_id(input logic [15:0] ins, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic urs, input logic urt,
                            input logic [5:0] ctl);
        instr_ID = ins;
        rd1_ID = ins + 16'h1000;
        rd2_ID = ins + 16'h2000;
        pcs_ID = ins + 16'h0002;
        rs_ID = rs; rt_ID = rt; rd_ID = rd;
        use_rs_ID = urs; use_rt_ID = urt; ctrl_ID = ctl;
    endtask

    task automatic check_stage(input string tag, input logic ev, input logic [15:0] ei,
                               input logic [3:0] ers, input logic [3:0] ert,
                               input logic [3:0] erd, input logic [5:0] ectl);
        check({tag, ".valid"}, 16'(valid_EX), 16'(ev));
        check({tag, ".instr"}, instr_EX, ei);
        check({tag, ".rd1"},   rd1_EX, ev ? ei + 16'h1000 : 16'h0000);
        check({tag, ".rd2"},   rd2_EX, ev ? ei + 16'h2000 : 16'h0000);
        check({tag, ".pcs"},   pcs_EX, ev ? ei + 16'h0002 : 16'h0000);
        check({tag, ".rs"},    16'(rs_EX), 16'(ers));
        check({tag, ".rt"},    16'(rt_EX), 16'(ert));
        check({tag, ".rd"},    16'(rd_EX), 16'(erd));
        check({tag, ".ctrl"},  16'(ctrl_EX), 16'(ectl));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        rst_n = 1'b0; flush = 1'b0; freeze = 1'b0;
        rd_MEM = '0; regwrite_MEM = 1'b0; rd_WB = '0; regwrite_WB = 1'b0;
        drive_id(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'h0);

        //          rst fl fz instr     rs rt rd urs urt ctrl    rdm rwm rdw rww  ev  e_instr  ers ert erd e_ctrl  fa     fb     st
        vecs[0]  = mk(0, 0, 0, 16'hA123, 1, 2, 3, 1, 1, C_ADD,  0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 6'h00, 2'b00, 2'b00, 0);
        vecs[1]  = mk(0, 0, 0, 16'hA123, 1, 2, 3, 1, 1, C_ADD,  1, 1, 2, 1,  0, 16'h0000, 0, 0, 0, 6'h00, 2'b00, 2'b00, 0);
        vecs[2]  = mk(1, 0, 0, 16'hA123, 1, 2, 3, 1, 1, C_ADD,  1, 1, 2, 1,  1, 16'hA123, 1, 2, 3, C_ADD, 2'b10, 2'b01, 0);
        vecs[3]  = mk(1, 0, 0, 16'hB345, 3, 4, 6, 1, 1, C_ADD,  3, 1, 3, 1,  1, 16'hB345, 3, 4, 6, C_ADD, 2'b10, 2'b00, 0);
        vecs[4]  = mk(1, 0, 1, 16'hCCCC, 7, 7, 7, 1, 1, C_ADD,  3, 0, 3, 1,  1, 16'hB345, 3, 4, 6, C_ADD, 2'b01, 2'b00, 0);
        vecs[5]  = mk(1, 0, 0, 16'hD000, 5, 0, 7, 1, 1, C_ADD,  0, 1, 0, 1,  1, 16'hD000, 5, 0, 7, C_ADD, 2'b00, 2'b00, 0);
        vecs[6]  = mk(1, 0, 1, 16'h1111, 1, 1, 1, 1, 1, C_LW,   0, 0, 0, 0,  1, 16'hD000, 5, 0, 7, C_ADD, 2'b00, 2'b00, 0);
        vecs[7]  = mk(1, 0, 1, 16'h2222, 2, 2, 2, 1, 0, C_SW,   0, 0, 0, 0,  1, 16'hD000, 5, 0, 7, C_ADD, 2'b00, 2'b00, 0);
        vecs[8]  = mk(1, 0, 1, 16'h3333, 3, 3, 3, 0, 1, C_HLT,  0, 0, 0, 0,  1, 16'hD000, 5, 0, 7, C_ADD, 2'b00, 2'b00, 0);
        vecs[9]  = mk(1, 0, 0, 16'hE777, 8, 9, 10, 1, 1, C_SW,  9, 1, 8, 1,  1, 16'hE777, 8, 9, 10, C_SW, 2'b01, 2'b10, 0);
        vecs[10] = mk(1, 1, 0, 16'hF111, 1, 2, 3, 1, 1, C_ADD,  0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 6'h00, 2'b00, 2'b00, 0);

        for (int i = 0; i < 11; i++) begin
            string tag;
            @(negedge clk);
            rst_n = vecs[i].rst_n; flush = vecs[i].flush; freeze = vecs[i].freeze;
            drive_id(vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                     vecs[i].urs, vecs[i].urt, vecs[i].ctrl);
            rd_MEM = vecs[i].rd_mem; regwrite_MEM = vecs[i].rw_mem;
            rd_WB = vecs[i].rd_wb; regwrite_WB = vecs[i].rw_wb;
            tick();
            tag = $sformatf("vec%0d", i);
            check_stage(tag, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_rs,
                        vecs[i].e_rt, vecs[i].e_rd, vecs[i].e_ctrl);
            check({tag, ".fwdA"},  16'(ForwardA), 16'(vecs[i].e_fa));
            check({tag, ".fwdB"},  16'(ForwardB), 16'(vecs[i].e_fb));
            check({tag, ".stall"}, 16'(stall_ID), 16'(vecs[i].e_stall));
        end

        // Load-use: LW R5 in EX, ADD reading R5 in ID, with one freeze cycle
        // in the middle of the stall.
        @(negedge clk);
        flush = 1'b0; freeze = 1'b0;
        rd_MEM = '0; regwrite_MEM = 1'b0; rd_WB = '0; regwrite_WB = 1'b0;
        drive_id(16'h8512, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, C_LW);
        tick();
        check_stage("lu.lw", 1'b1, 16'h8512, 4'd1, 4'd0, 4'd5, C_LW);
        @(negedge clk);
        drive_id(16'h0156, 4'd5, 4'd6, 4'd1, 1'b1, 1'b1, C_ADD);
        #1 check("lu.stall_pre", 16'(stall_ID), 16'd1);
        freeze = 1'b1;
        tick();
        check_stage("lu.frz", 1'b1, 16'h8512, 4'd1, 4'd0, 4'd5, C_LW);
        check("lu.stall_frz", 16'(stall_ID), 16'd1);
        @(negedge clk);
        freeze = 1'b0;
        tick();
        check_stage("lu.bub", 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0, 6'h00);
        check("lu.stall_bub", 16'(stall_ID), 16'd0);
        tick();
        check_stage("lu.add", 1'b1, 16'h0156, 4'd5, 4'd6, 4'd1, C_ADD);
        check("lu.stall_add", 16'(stall_ID), 16'd0);

        // Flush together with a load-use hazard: flush wins, single bubble.
        @(negedge clk);
        drive_id(16'h8512, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, C_LW);
        tick();
        check_stage("fs.lw", 1'b1, 16'h8512, 4'd1, 4'd0, 4'd5, C_LW);
        @(negedge clk);
        drive_id(16'h0156, 4'd5, 4'd6, 4'd1, 1'b1, 1'b1, C_ADD);
        flush = 1'b1;
        #1 check("fs.stall_flush", 16'(stall_ID), 16'd0);
        tick();
        check_stage("fs.bub", 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0, 6'h00);
        @(negedge clk);
        flush = 1'b0;
        #1 check("fs.stall_after", 16'(stall_ID), 16'd0);
        tick();
        check_stage("fs.add", 1'b1, 16'h0156, 4'd5, 4'd6, 4'd1, C_ADD);

        // Reset in the middle of a stall.
        @(negedge clk);
        drive_id(16'h8512, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, C_LW);
        tick();
        @(negedge clk);
        drive_id(16'h0156, 4'd5, 4'd6, 4'd1, 1'b1, 1'b1, C_ADD);
        #1 check("rs.stall_pre", 16'(stall_ID), 16'd1);
        rst_n = 1'b0;
        tick();
        check_stage("rs.rst", 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0, 6'h00);
        check("rs.stall_rst", 16'(stall_ID), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_stage("rs.add", 1'b1, 16'h0156, 4'd5, 4'd6, 4'd1, C_ADD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_id_ex_pipe
